// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths, ALU select encodings and the ID/EX pipeline record.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_AW    = 5;
    localparam int ALU_SEL_W = 4;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_NOP  = 4'hF
    } alu_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        logic [REG_AW-1:0]    rs1_addr;
        logic [REG_AW-1:0]    rs2_addr;
        logic [REG_AW-1:0]    rd_addr;
        logic [ALU_SEL_W-1:0] alu_sel;
        logic                 alu_src_pc;
        logic                 alu_src_imm;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
    } id_ex_t;

    // Empty stage: all control off, ALU idle, datapath zeroed.
    function automatic id_ex_t id_ex_bubble();
        id_ex_t b;
        b         = '0;
        b.alu_sel = ALU_NOP;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: EX operand forwarding and ID hazard detection.
// ID_EX_FORWARDING_EN selects MEM/WB bypass with load-use stalls; otherwise no bypass and stall on any RAW.
module forward_unit
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic              mem_reg_write_i,
    input  logic [XLEN-1:0]   mem_result_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic              wb_reg_write_i,
    input  logic [XLEN-1:0]   wb_result_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_reg_write_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    output logic [XLEN-1:0]   rs1_fwd_o,
    output logic [XLEN-1:0]   rs2_fwd_o,
    output logic              hazard_stall_o
);

    // x0 is never a real producer.
    function automatic logic hit(input logic we, input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
        return we && rd != '0 && rd == rs;
    endfunction

`ifdef ID_EX_FORWARDING_EN
    assign rs1_fwd_o = hit(mem_reg_write_i, mem_rd_addr_i, rs1_addr_i) ? mem_result_i :
                       hit(wb_reg_write_i, wb_rd_addr_i, rs1_addr_i)   ? wb_result_i  : rs1_data_i;
    assign rs2_fwd_o = hit(mem_reg_write_i, mem_rd_addr_i, rs2_addr_i) ? mem_result_i :
                       hit(wb_reg_write_i, wb_rd_addr_i, rs2_addr_i)   ? wb_result_i  : rs2_data_i;
    assign hazard_stall_o = id_valid_i && ex_valid_i && ex_mem_read_i &&
                            (hit(1'b1, ex_rd_addr_i, id_rs1_addr_i) || hit(1'b1, ex_rd_addr_i, id_rs2_addr_i));
    logic unused_fwd;
    assign unused_fwd = ex_reg_write_i;
`else
    assign rs1_fwd_o = rs1_data_i;
    assign rs2_fwd_o = rs2_data_i;
    assign hazard_stall_o = id_valid_i &&
                            (hit(ex_valid_i & ex_reg_write_i, ex_rd_addr_i, id_rs1_addr_i) ||
                             hit(ex_valid_i & ex_reg_write_i, ex_rd_addr_i, id_rs2_addr_i) ||
                             hit(mem_reg_write_i, mem_rd_addr_i, id_rs1_addr_i) ||
                             hit(mem_reg_write_i, mem_rd_addr_i, id_rs2_addr_i));
    logic unused_fwd;
    assign unused_fwd = ^{rs1_addr_i, rs2_addr_i, mem_result_i, wb_rd_addr_i, wb_reg_write_i, wb_result_i, ex_mem_read_i};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand selection, flush/stall and hazard bubbles.
// Build with ID_EX_FORWARDING_EN for MEM/WB operand bypass; without it hazard_stall covers all RAW cases.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [REG_AW-1:0]    id_rs1_addr,
    input  logic [REG_AW-1:0]    id_rs2_addr,
    input  logic [REG_AW-1:0]    id_rd_addr,
    input  logic [ALU_SEL_W-1:0] id_alu_sel,
    input  logic                 id_alu_src_pc,
    input  logic                 id_alu_src_imm,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [REG_AW-1:0]    mem_rd_addr,
    input  logic                 mem_reg_write,
    input  logic [XLEN-1:0]      mem_result,
    input  logic [REG_AW-1:0]    wb_rd_addr,
    input  logic                 wb_reg_write,
    input  logic [XLEN-1:0]      wb_result,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_a,
    output logic [XLEN-1:0]      ex_b,
    output logic [ALU_SEL_W-1:0] ex_alu_sel,
    output logic [XLEN-1:0]      ex_store_data,
    output logic [XLEN-1:0]      ex_pc,
    output logic [REG_AW-1:0]    ex_rd_addr,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 hazard_stall
);

    id_ex_t          stage_q, stage_d, cap;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    always_comb begin
        cap             = '0;
        cap.valid       = id_valid;
        cap.pc          = id_pc;
        cap.rs1_data    = id_rs1_data;
        cap.rs2_data    = id_rs2_data;
        cap.imm         = id_imm;
        cap.rs1_addr    = id_rs1_addr;
        cap.rs2_addr    = id_rs2_addr;
        cap.rd_addr     = id_rd_addr;
        cap.alu_sel     = id_alu_sel;
        cap.alu_src_pc  = id_alu_src_pc;
        cap.alu_src_imm = id_alu_src_imm;
        cap.reg_write   = id_reg_write & id_valid;
        cap.mem_read    = id_mem_read & id_valid;
        cap.mem_write   = id_mem_write & id_valid;
    end

    // flush beats stall beats hazard bubble beats load
    always_comb begin
        stage_d = flush ? id_ex_bubble() : stall ? stage_q : hazard_stall ? id_ex_bubble() : cap;
    end

    always_ff @(posedge clk) begin
        if (rst) stage_q <= id_ex_bubble();
        else     stage_q <= stage_d;
    end

    forward_unit u_fwd (
        .rs1_addr_i     (stage_q.rs1_addr),
        .rs2_addr_i     (stage_q.rs2_addr),
        .rs1_data_i     (stage_q.rs1_data),
        .rs2_data_i     (stage_q.rs2_data),
        .mem_rd_addr_i  (mem_rd_addr),
        .mem_reg_write_i(mem_reg_write),
        .mem_result_i   (mem_result),
        .wb_rd_addr_i   (wb_rd_addr),
        .wb_reg_write_i (wb_reg_write),
        .wb_result_i    (wb_result),
        .id_valid_i     (id_valid),
        .id_rs1_addr_i  (id_rs1_addr),
        .id_rs2_addr_i  (id_rs2_addr),
        .ex_valid_i     (stage_q.valid),
        .ex_mem_read_i  (ex_mem_read),
        .ex_reg_write_i (ex_reg_write),
        .ex_rd_addr_i   (stage_q.rd_addr),
        .rs1_fwd_o      (rs1_fwd),
        .rs2_fwd_o      (rs2_fwd),
        .hazard_stall_o (hazard_stall)
    );

    assign ex_valid      = stage_q.valid;
    assign ex_a          = stage_q.alu_src_pc ? stage_q.pc : rs1_fwd;
    assign ex_b          = stage_q.alu_src_imm ? stage_q.imm : rs2_fwd;
    assign ex_alu_sel    = stage_q.alu_sel;
    assign ex_store_data = rs2_fwd;
    assign ex_pc         = stage_q.pc;
    assign ex_rd_addr    = stage_q.rd_addr;
    assign ex_reg_write  = stage_q.valid & stage_q.reg_write;
    assign ex_mem_read   = stage_q.valid & stage_q.mem_read;
    assign ex_mem_write  = stage_q.valid & stage_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table, hand-written corner sequences and a randomized reference model.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, id_alu_src_pc, id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, mem_rd_addr, wb_rd_addr;
    logic [3:0]  id_alu_sel;
    logic        stall, flush, mem_reg_write, wb_reg_write;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall;
    logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
    logic [3:0]  ex_alu_sel;
    logic [4:0]  ex_rd_addr;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_alu_sel(id_alu_sel), .id_alu_src_pc(id_alu_src_pc),
        .id_alu_src_imm(id_alu_src_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .stall(stall), .flush(flush), .mem_rd_addr(mem_rd_addr),
        .mem_reg_write(mem_reg_write), .mem_result(mem_result), .wb_rd_addr(wb_rd_addr),
        .wb_reg_write(wb_reg_write), .wb_result(wb_result), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_alu_sel(ex_alu_sel), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .hazard_stall(hazard_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; flush = 0; stall = 0; id_valid = 0;
        id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_sel = ALU_ADD;
        id_alu_src_pc = 0; id_alu_src_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0; wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    typedef struct {
        logic rst, flush, stall, valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0] rs1a, rs2a, rd;
        logic [3:0] alu;
        logic srcpc, srcimm, rw, mr, mw;
        logic e_valid, chk_dp;
        logic [31:0] e_a, e_b, e_pc;
        logic [3:0] e_alu;
        logic e_rw, e_mr, e_mw;
    } vec_t;

    vec_t tbl[11];

    // Reference model: the instruction currently held in EX, plus whether its datapath is meaningful.
    typedef struct {
        logic valid, dc;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0] rs1a, rs2a, rd;
        logic [3:0] alu;
        logic srcpc, srcimm, rw, mr, mw;
    } ex_model_t;

    ex_model_t m, m_next;

    function automatic ex_model_t empty_ex(input logic dont_care);
        ex_model_t e;
        e = '{default: '0};
        e.alu = ALU_NOP;
        e.dc = dont_care;
        return e;
    endfunction

    function automatic logic reads(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && rd != 0 && rd == rs;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] regval);
`ifdef ID_EX_FORWARDING_EN
        if (reads(mem_reg_write, mem_rd_addr, a)) return mem_result;
        if (reads(wb_reg_write, wb_rd_addr, a)) return wb_result;
`endif
        return regval;
    endfunction

    function automatic logic model_hazard();
        logic ex_hit, mem_hit;
        ex_hit  = reads(1'b1, m.rd, id_rs1_addr) || reads(1'b1, m.rd, id_rs2_addr);
        mem_hit = reads(mem_reg_write, mem_rd_addr, id_rs1_addr) || reads(mem_reg_write, mem_rd_addr, id_rs2_addr);
`ifdef ID_EX_FORWARDING_EN
        return id_valid && m.valid && m.mr && ex_hit;
`else
        return id_valid && ((m.valid && m.rw && ex_hit) || mem_hit);
`endif
    endfunction

    logic fwd_en;

    initial begin
`ifdef ID_EX_FORWARDING_EN
        fwd_en = 1;
`else
        fwd_en = 0;
`endif
        tbl[0]  = '{1,0,0,1, 32'h50,32'h1,32'h2,32'h3, 5'd1,5'd2,5'd3, ALU_ADD, 0,0,1,1,1, 0,1, 32'h0,32'h0,32'h0, ALU_NOP, 0,0,0};
        tbl[1]  = '{0,0,0,1, 32'h100,32'd5,32'd7,32'h99, 5'd1,5'd2,5'd3, ALU_ADD, 0,0,1,0,0, 1,1, 32'd5,32'd7,32'h100, ALU_ADD, 1,0,0};
        tbl[2]  = '{0,0,0,1, 32'h200,32'h11,32'h22,32'h44, 5'd7,5'd8,5'd6, ALU_SUB, 1,1,1,0,0, 1,1, 32'h200,32'h44,32'h200, ALU_SUB, 1,0,0};
        tbl[3]  = '{0,0,0,0, 32'h300,32'h33,32'h44,32'h0, 5'd3,5'd6,5'd5, ALU_XOR, 0,0,1,1,1, 0,1, 32'h33,32'h44,32'h300, ALU_XOR, 0,0,0};
        tbl[4]  = '{0,0,0,1, 32'h400,32'h55,32'h66,32'h10, 5'd1,5'd2,5'd9, ALU_ADD, 0,1,1,1,0, 1,1, 32'h55,32'h10,32'h400, ALU_ADD, 1,1,0};
        tbl[5]  = '{0,0,1,1, 32'h500,32'h1,32'h2,32'h3, 5'd9,5'd9,5'd10, ALU_OR, 1,1,1,0,0, 1,1, 32'h55,32'h10,32'h400, ALU_ADD, 1,1,0};
        tbl[6]  = tbl[5];
        tbl[7]  = tbl[5];
        tbl[8]  = '{0,1,1,1, 32'h600,32'h1,32'h2,32'h3, 5'd1,5'd2,5'd11, ALU_OR, 0,0,1,1,1, 0,0, 32'h0,32'h0,32'h0, ALU_NOP, 0,0,0};
        tbl[9]  = '{0,0,0,1, 32'h700,32'h77,32'h88,32'h12, 5'd10,5'd11,5'd12, ALU_AND, 0,0,1,0,1, 1,1, 32'h77,32'h88,32'h700, ALU_AND, 1,0,1};
        tbl[10] = '{1,0,0,1, 32'h800,32'h1,32'h2,32'h3, 5'd1,5'd2,5'd13, ALU_SUB, 1,1,1,1,1, 0,1, 32'h0,32'h0,32'h0, ALU_NOP, 0,0,0};

        clear_inputs();
        #1;
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; flush = tbl[i].flush; stall = tbl[i].stall; id_valid = tbl[i].valid;
            id_pc = tbl[i].pc; id_rs1_data = tbl[i].rs1d; id_rs2_data = tbl[i].rs2d; id_imm = tbl[i].imm;
            id_rs1_addr = tbl[i].rs1a; id_rs2_addr = tbl[i].rs2a; id_rd_addr = tbl[i].rd; id_alu_sel = tbl[i].alu;
            id_alu_src_pc = tbl[i].srcpc; id_alu_src_imm = tbl[i].srcimm;
            id_reg_write = tbl[i].rw; id_mem_read = tbl[i].mr; id_mem_write = tbl[i].mw;
            tick();
            chk($sformatf("vec%0d ex_valid", i), {31'b0, ex_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("vec%0d ex_alu_sel", i), {28'b0, ex_alu_sel}, {28'b0, tbl[i].e_alu});
            chk($sformatf("vec%0d ex_reg_write", i), {31'b0, ex_reg_write}, {31'b0, tbl[i].e_rw});
            chk($sformatf("vec%0d ex_mem_read", i), {31'b0, ex_mem_read}, {31'b0, tbl[i].e_mr});
            chk($sformatf("vec%0d ex_mem_write", i), {31'b0, ex_mem_write}, {31'b0, tbl[i].e_mw});
            if (tbl[i].chk_dp) begin
                chk($sformatf("vec%0d ex_a", i), ex_a, tbl[i].e_a);
                chk($sformatf("vec%0d ex_b", i), ex_b, tbl[i].e_b);
                chk($sformatf("vec%0d ex_pc", i), ex_pc, tbl[i].e_pc);
            end
        end

        // Load-use: EX holds a load to x4, ID reads x4.
        clear_inputs();
        id_valid = 1; id_pc = 32'h900; id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 4;
        id_reg_write = 1; id_mem_read = 1;
        tick();
        id_pc = 32'hA00; id_rs1_addr = 1; id_rs2_addr = 4; id_rd_addr = 5; id_mem_read = 0;
        #1;
        chk("loaduse hazard_stall", {31'b0, hazard_stall}, 32'd1);
        tick();
        chk("loaduse bubble ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("loaduse bubble ex_reg_write", {31'b0, ex_reg_write}, 32'd0);
        chk("loaduse hazard cleared", {31'b0, hazard_stall}, 32'd0);
        tick();
        chk("loaduse reload ex_valid", {31'b0, ex_valid}, 32'd1);
        chk("loaduse reload ex_pc", ex_pc, 32'hA00);

        // Forwarding priority: MEM over WB over regfile, x0 never bypassed.
        id_pc = 32'hB00; id_rs1_addr = 3; id_rs2_addr = 2; id_rs1_data = 32'h11; id_rs2_data = 32'h12; id_rd_addr = 7;
        tick();
        stall = 1; id_valid = 0;
        mem_rd_addr = 3; mem_reg_write = 1; mem_result = 32'hAA;
        wb_rd_addr = 3; wb_reg_write = 1; wb_result = 32'hBB;
        #1;
        chk("fwd mem ex_a", ex_a, fwd_en ? 32'hAA : 32'h11);
        chk("fwd no-match store_data", ex_store_data, 32'h12);
        mem_reg_write = 0;
        #1;
        chk("fwd wb ex_a", ex_a, fwd_en ? 32'hBB : 32'h11);
        stall = 0; id_valid = 1; id_pc = 32'hC00; id_rs1_addr = 0; id_rs1_data = 32'h22; id_rd_addr = 8;
        mem_rd_addr = 0; mem_reg_write = 1; wb_rd_addr = 0; wb_reg_write = 1;
        tick();
        chk("fwd x0 ex_a", ex_a, 32'h22);
        chk("fwd x0 ex_pc", ex_pc, 32'hC00);

        // RAW against MEM producer with EX empty.
        clear_inputs();
        flush = 1;
        tick();
        flush = 0; id_valid = 1; id_rs1_addr = 5; mem_rd_addr = 5; mem_reg_write = 1;
        #1;
        chk("mem raw hazard_stall", {31'b0, hazard_stall}, fwd_en ? 32'd0 : 32'd1);
        id_rs1_addr = 0; mem_rd_addr = 0;
        #1;
        chk("mem raw x0 hazard_stall", {31'b0, hazard_stall}, 32'd0);

        // Randomized run against the reference model.
        clear_inputs();
        rst = 1;
        tick();
        m = empty_ex(1'b0);
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            id_valid = 1'($urandom_range(0, 1));
            id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
            id_rd_addr = 5'($urandom_range(0, 7)); id_alu_sel = 4'($urandom_range(0, 15));
            id_alu_src_pc = 1'($urandom_range(0, 1)); id_alu_src_imm = 1'($urandom_range(0, 1));
            id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = 1'($urandom_range(0, 1));
            id_mem_write = 1'($urandom_range(0, 1));
            mem_rd_addr = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom_range(0, 1)); mem_result = $urandom;
            wb_rd_addr = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom_range(0, 1)); wb_result = $urandom;
            #1;
            chk("rnd hazard_stall", {31'b0, hazard_stall}, {31'b0, model_hazard()});
            chk("rnd ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
            chk("rnd ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m.valid & m.rw});
            chk("rnd ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m.valid & m.mr});
            chk("rnd ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m.valid & m.mw});
            chk("rnd ex_alu_sel", {28'b0, ex_alu_sel}, {28'b0, m.alu});
            if (!m.dc) begin
                chk("rnd ex_pc", ex_pc, m.pc);
                chk("rnd ex_rd_addr", {27'b0, ex_rd_addr}, {27'b0, m.rd});
                chk("rnd ex_a", ex_a, m.srcpc ? m.pc : operand(m.rs1a, m.rs1d));
                chk("rnd ex_b", ex_b, m.srcimm ? m.imm : operand(m.rs2a, m.rs2d));
                chk("rnd ex_store_data", ex_store_data, operand(m.rs2a, m.rs2d));
            end
            if (rst) m_next = empty_ex(1'b0);
            else if (flush) m_next = empty_ex(1'b1);
            else if (stall) m_next = m;
            else if (model_hazard()) m_next = empty_ex(1'b1);
            else begin
                m_next = '{valid: id_valid, dc: 1'b0, pc: id_pc, rs1d: id_rs1_data, rs2d: id_rs2_data, imm: id_imm,
                           rs1a: id_rs1_addr, rs2a: id_rs2_addr, rd: id_rd_addr, alu: id_alu_sel,
                           srcpc: id_alu_src_pc, srcimm: id_alu_src_imm, rw: id_reg_write & id_valid,
                           mr: id_mem_read & id_valid, mw: id_mem_write & id_valid};
            end
            tick();
            m = m_next;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
